// File: rtl/stack_ctrl.sv
// Hardware stack sequencer: accepts PUSH/POP/PEEK/SETSP requests and drives the SP strobes
// and stack RAM port, flagging overflow/underflow and returning read data with a done pulse.
module stack_ctrl #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rsp_data,
    output logic          ovf_sticky,
    output logic          udf_sticky,
    input  logic          clr_sticky,
    output logic          full,
    output logic          empty,
    input  logic [AW-1:0] sp_value,
    output logic          sp_inc,
    output logic          sp_dec,
    output logic          sp_load,
    output logic [AW-1:0] sp_din,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StRdWait
    } state_e;

    typedef enum logic [1:0] {
        OpPush  = 2'b00,
        OpPop   = 2'b01,
        OpPeek  = 2'b10,
        OpSetsp = 2'b11
    } op_e;

    localparam logic [AW-1:0] DepthVal = AW'(DEPTH);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [DW-1:0] data_q, data_d;
    logic          fault_q, fault_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] rsp_q, rsp_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          ovf_set, udf_set;
    logic          accept_fault;
    logic [AW-1:0] sp_top;

    assign full      = (sp_value == DepthVal);
    assign empty     = (sp_value == '0);
    assign sp_top    = sp_value - AW'(1);
    assign req_ready = (state_q == StIdle);

    assign done       = done_q;
    assign err        = err_q;
    assign rsp_data   = rsp_q;
    assign ovf_sticky = ovf_q;
    assign udf_sticky = udf_q;

    // Fault is decided against the SP seen at accept; EXEC then only replays the verdict.
    always_comb begin
        accept_fault = 1'b0;
        unique case (op_e'(req_op))
            OpPush:        accept_fault = full;
            OpPop, OpPeek: accept_fault = empty;
            OpSetsp:       accept_fault = (req_data[AW-1:0] > DepthVal);
            default:       accept_fault = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        fault_d   = fault_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rsp_d     = rsp_q;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        sp_load   = 1'b0;
        sp_din    = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    data_d  = req_data;
                    fault_d = accept_fault;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (fault_q) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ovf_set = (op_q == OpPush);
                    udf_set = (op_q == OpPop) || (op_q == OpPeek);
                    state_d = StIdle;
                end else begin
                    unique case (op_q)
                        OpPush: begin
                            mem_addr  = sp_value;
                            mem_wdata = data_q;
                            mem_we    = 1'b1;
                            sp_inc    = 1'b1;
                            done_d    = 1'b1;
                            state_d   = StIdle;
                        end
                        OpPop: begin
                            mem_addr = sp_top;
                            mem_re   = 1'b1;
                            sp_dec   = 1'b1;
                            state_d  = StRdWait;
                        end
                        OpPeek: begin
                            mem_addr = sp_top;
                            mem_re   = 1'b1;
                            state_d  = StRdWait;
                        end
                        OpSetsp: begin
                            sp_load = 1'b1;
                            sp_din  = data_q[AW-1:0];
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StRdWait: begin
                rsp_d   = mem_rdata;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new fault in the same cycle as clr_sticky keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~clr_sticky);
        udf_d = udf_set | (udf_q & ~clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpPush;
            data_q  <= '0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: one DUT at DEPTH=1023 with SP register and RAM models, and a
// second at DEPTH=7 for the SETSP range fault.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic        done, err;
    logic [15:0] rsp_data;
    logic        ovf_sticky, udf_sticky, clr_sticky;
    logic        full, empty;
    logic [9:0]  sp = '0;
    logic        sp_inc, sp_dec, sp_load;
    logic [9:0]  sp_din, mem_addr;
    logic        mem_we, mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ram [1024];

    logic        req_valid7;
    logic        req_ready7;
    logic [1:0]  req_op7;
    logic [15:0] req_data7;
    logic        done7, err7;
    logic [15:0] rsp_data7;
    logic        ovf7, udf7;
    logic        full7, empty7;
    logic [9:0]  sp7 = '0;
    logic        sp_inc7, sp_dec7, sp_load7;
    logic [9:0]  sp_din7, mem_addr7;
    logic        mem_we7, mem_re7;
    logic [15:0] mem_wdata7;
    logic [15:0] mem_rdata7;

    int n_checks = 0;
    int n_errors = 0;
    int multi_strobe = 0;

    assign mem_rdata7 = '0;

    always #5 clk = ~clk;

    stack_ctrl #(.AW(10), .DW(16), .DEPTH(1023)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .done(done), .err(err), .rsp_data(rsp_data),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .clr_sticky(clr_sticky),
        .full(full), .empty(empty), .sp_value(sp), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .sp_load(sp_load), .sp_din(sp_din), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    stack_ctrl #(.AW(10), .DW(16), .DEPTH(7)) u_dut7 (
        .clk(clk), .rst(rst), .req_valid(req_valid7), .req_ready(req_ready7), .req_op(req_op7),
        .req_data(req_data7), .done(done7), .err(err7), .rsp_data(rsp_data7),
        .ovf_sticky(ovf7), .udf_sticky(udf7), .clr_sticky(clr_sticky),
        .full(full7), .empty(empty7), .sp_value(sp7), .sp_inc(sp_inc7), .sp_dec(sp_dec7),
        .sp_load(sp_load7), .sp_din(sp_din7), .mem_addr(mem_addr7), .mem_we(mem_we7),
        .mem_re(mem_re7), .mem_wdata(mem_wdata7), .mem_rdata(mem_rdata7)
    );

    // SP register and synchronous-read RAM models; SP is deliberately not reset by rst.
    always @(posedge clk) begin
        if (sp_inc) sp <= sp + 10'd1;
        else if (sp_dec) sp <= sp - 10'd1;
        else if (sp_load) sp <= sp_din;
        if (sp_inc7) sp7 <= sp7 + 10'd1;
        else if (sp_dec7) sp7 <= sp7 - 10'd1;
        else if (sp_load7) sp7 <= sp_din7;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
        if ((32'(sp_inc) + 32'(sp_dec) + 32'(sp_load)) > 1) multi_strobe <= multi_strobe + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and stop in its done cycle (or after a bounded wait).
    task automatic run_op(input logic [1:0] op, input logic [15:0] d, output logic e,
                          output logic [15:0] r, output int lat);
        check("ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 6) begin
            tick();
            lat++;
        end
        check("done_timeout", 32'(done), 32'd1);
        e = err;
        r = rsp_data;
    endtask

    logic        e;
    logic [15:0] r;
    int          lat;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0; clr_sticky = 1'b0;
        req_valid7 = 1'b0; req_op7 = 2'b00; req_data7 = '0;
        tick();
        tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rsp", 32'(rsp_data), 32'd0);
        check("rst_sticky", 32'({ovf_sticky, udf_sticky}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        tick();

        // PUSH 0xA5A5, step by step
        req_valid = 1'b1; req_op = 2'b00; req_data = 16'hA5A5;
        tick();
        req_valid = 1'b0;
        check("push_exec_we", 32'({mem_we, sp_inc, sp_dec, mem_re}), 32'b1100);
        check("push_exec_addr", 32'(mem_addr), 32'd0);
        check("push_exec_wdata", 32'(mem_wdata), 32'hA5A5);
        check("push_exec_done", 32'(done), 32'd0);
        tick();
        check("push_done", 32'({done, err}), 32'b10);
        check("push_sp", 32'(sp), 32'd1);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        run_op(2'b01, 16'h0, e, r, lat);
        check("pop_a5a5", 32'(r), 32'hA5A5);
        check("pop_lat", 32'(lat), 32'd3);

        // Back-to-back, each accepted in the previous done cycle
        run_op(2'b00, 16'h1111, e, r, lat);
        check("push1_lat", 32'(lat), 32'd2);
        run_op(2'b00, 16'h2222, e, r, lat);
        check("push2_sp", 32'(sp), 32'd2);
        run_op(2'b01, 16'h0, e, r, lat);
        check("pop_2222", 32'({e, r}), 32'h2222);
        run_op(2'b01, 16'h0, e, r, lat);
        check("pop_1111", 32'({e, r}), 32'h1111);
        check("b2b_empty", 32'(empty), 32'd1);
        check("b2b_sp", 32'(sp), 32'd0);
        tick();

        // POP on empty stack
        req_valid = 1'b1; req_op = 2'b01; req_data = '0;
        tick();
        req_valid = 1'b0;
        check("udf_exec_strobes", 32'({mem_re, sp_dec, sp_inc, mem_we}), 32'd0);
        tick();
        check("udf_done_err", 32'({done, err}), 32'b11);
        check("udf_sticky", 32'({ovf_sticky, udf_sticky}), 32'b01);
        check("udf_sp", 32'(sp), 32'd0);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("udf_cleared", 32'(udf_sticky), 32'd0);

        // PEEK after PUSH 0xBEEF
        run_op(2'b00, 16'hBEEF, e, r, lat);
        tick();
        req_valid = 1'b1; req_op = 2'b10; req_data = '0;
        tick();
        req_valid = 1'b0;
        check("peek_exec", 32'({mem_re, sp_dec}), 32'b10);
        check("peek_addr", 32'(mem_addr), 32'd0);
        tick();
        check("peek_rdwait_done", 32'(done), 32'd0);
        tick();
        check("peek_done", 32'({done, err}), 32'b10);
        check("peek_rsp", 32'(rsp_data), 32'hBEEF);
        check("peek_sp", 32'(sp), 32'd1);
        tick();

        // SETSP to DEPTH, then overflowing PUSH
        run_op(2'b11, 16'd1023, e, r, lat);
        check("setsp_ok", 32'({e, 6'(lat)}), 32'd2);
        check("setsp_full", 32'({full, sp}), {21'd0, 1'b1, 10'd1023});
        run_op(2'b00, 16'h1234, e, r, lat);
        check("ovf_err", 32'(e), 32'd1);
        check("ovf_sticky", 32'({ovf_sticky, udf_sticky}), 32'b10);
        check("ovf_sp", 32'(sp), 32'd1023);
        check("rsp_hold", 32'(rsp_data), 32'hBEEF);
        run_op(2'b11, 16'd1, e, r, lat);
        check("setsp_1", 32'({e, sp}), 32'd1);
        tick();

        // Reset during RD_WAIT of a POP
        req_valid = 1'b1; req_op = 2'b01; req_data = '0;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_done", 32'({done, err}), 32'd0);
        check("rst_mid_rsp", 32'(rsp_data), 32'd0);
        check("rst_mid_strobes",
              32'({mem_we, mem_re, sp_inc, sp_dec, sp_load, ovf_sticky}), 32'd0);
        check("rst_mid_sp", 32'(sp), 32'd0);
        tick();
        check("rst_mid_nodone", 32'({done, req_ready}), 32'b01);

        // DEPTH=7 instance: out-of-range SETSP faults without side effects
        req_valid7 = 1'b1; req_op7 = 2'b11; req_data7 = 16'd8;
        tick();
        req_valid7 = 1'b0;
        check("d7_exec_load", 32'(sp_load7), 32'd0);
        tick();
        check("d7_err", 32'({done7, err7}), 32'b11);
        check("d7_sp", 32'(sp7), 32'd0);
        check("d7_nosticky", 32'({ovf7, udf7}), 32'd0);
        req_valid7 = 1'b1; req_op7 = 2'b11; req_data7 = 16'd7;
        tick();
        req_valid7 = 1'b0;
        tick();
        check("d7_set7", 32'({done7, err7, full7}), 32'b101);
        check("d7_sp7", 32'(sp7), 32'd7);

        check("one_sp_strobe", 32'(multi_strobe), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
